miner_work_ctrl: RTL and testbench

Work-sequencing controller placed between the host command interface and one double-SHA256 miner core. Accepts a work unit (midstate and 96-bit data tail) via valid/ready, loads it into the core, drives the core's active-high reset for a fixed window, and masks the pipeline-fill interval so stale results are never reported. Turns golden-nonce changes into entries in a small result FIFO and flags range exhaustion.

---
 rtl/miner_ctrl_pkg.sv | 17 +
 rtl/result_fifo.sv | 56 +++++
 rtl/miner_work_ctrl.sv | 147 ++++++++++++++
 tb/tb_miner_work_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_ctrl_pkg.sv
// Shared types and widths for the miner work controller and its result FIFO.
package miner_ctrl_pkg;

   localparam int MIDSTATE_W = 256;
   localparam int DATA_W     = 96;
   localparam int NONCE_W    = 32;

   // Matches the double-SHA256 core pipeline depth.
   localparam int DEFAULT_HOLDOFF = 254;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } ctrl_state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous golden-nonce FIFO. Head reads as zero while empty; flush empties it in one cycle.
module result_fifo
   import miner_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [NONCE_W-1:0] push_data,
   output logic               full,
   output logic               empty,
   output logic [NONCE_W-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [NONCE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW:0]        count_q;
   logic               do_push;
   logic               do_pop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == (AW+1)'(DEPTH));
   assign do_pop = pop && !empty;
   // A pop frees its slot in the same cycle, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset && !flush && do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/miner_work_ctrl.sv
// Sequences one work unit into a double-SHA256 core: load, core reset window, run with
// pipeline-fill holdoff, and golden-nonce capture into a small result FIFO.
module miner_work_ctrl
   import miner_ctrl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned HOLDOFF      = DEFAULT_HOLDOFF,
   parameter logic [32:0] DONE_CYCLES  = 33'h1_0000_0100,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  work_valid,
   output logic                  work_ready,
   input  logic [MIDSTATE_W-1:0] work_midstate,
   input  logic [DATA_W-1:0]     work_data,
   output logic [MIDSTATE_W-1:0] miner_midstate,
   output logic [DATA_W-1:0]     miner_data,
   output logic                  miner_reset,
   input  logic [NONCE_W-1:0]    miner_golden_nonce,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [NONCE_W-1:0]    result_nonce,
   output logic                  busy,
   output logic                  exhausted,
   output logic                  overflow
);

   localparam int unsigned RCW = $clog2(RESET_CYCLES);

   ctrl_state_e           state_q, state_d;
   logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
   logic [32:0]           run_cnt_q, run_cnt_d;
   logic [NONCE_W-1:0]    prev_golden_q, prev_golden_d;
   logic [MIDSTATE_W-1:0] midstate_q, midstate_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  exhausted_q, exhausted_d;
   logic                  overflow_q, overflow_d;
   logic                  work_ready_q, miner_reset_q, busy_q;
   logic                  accept, holdoff, golden_push;
   logic                  fifo_full, fifo_empty;
   logic [NONCE_W-1:0]    fifo_head;

   assign accept  = work_valid && work_ready_q;
   assign holdoff = (run_cnt_q < 33'(HOLDOFF));

   // An accept preempts whatever the controller is doing, including a final RUN cycle.
   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      run_cnt_d     = run_cnt_q;
      prev_golden_d = prev_golden_q;
      midstate_d    = midstate_q;
      data_d        = data_q;
      exhausted_d   = exhausted_q;
      overflow_d    = overflow_q;
      golden_push   = 1'b0;
      if (accept) begin
         midstate_d    = work_midstate;
         data_d        = work_data;
         exhausted_d   = 1'b0;
         overflow_d    = 1'b0;
         prev_golden_d = '0;
         run_cnt_d     = '0;
         rst_cnt_d     = '0;
         state_d       = LOAD;
      end else begin
         case (state_q)
            LOAD: begin
               if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
                  state_d = RUN;
               end else begin
                  rst_cnt_d = rst_cnt_q + RCW'(1);
               end
            end
            RUN: begin
               run_cnt_d     = run_cnt_q + 33'd1;
               prev_golden_d = miner_golden_nonce;
               if ((miner_golden_nonce != prev_golden_q) && (miner_golden_nonce != '0) && !holdoff) begin
                  golden_push = 1'b1;
                  if (fifo_full && !result_ready) begin
                     overflow_d = 1'b1;
                  end
               end
               if (run_cnt_q == DONE_CYCLES - 33'd1) begin
                  exhausted_d = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         rst_cnt_q     <= '0;
         run_cnt_q     <= '0;
         prev_golden_q <= '0;
         midstate_q    <= '0;
         data_q        <= '0;
         exhausted_q   <= 1'b0;
         overflow_q    <= 1'b0;
         work_ready_q  <= 1'b0;
         miner_reset_q <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         run_cnt_q     <= run_cnt_d;
         prev_golden_q <= prev_golden_d;
         midstate_q    <= midstate_d;
         data_q        <= data_d;
         exhausted_q   <= exhausted_d;
         overflow_q    <= overflow_d;
         work_ready_q  <= (state_d != LOAD);
         miner_reset_q <= (state_d != RUN);
         busy_q        <= (state_d != IDLE);
      end
   end

   result_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_result_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (golden_push),
      .pop      (result_ready),
      .flush    (accept),
      .push_data(miner_golden_nonce),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   assign work_ready     = work_ready_q;
   assign miner_reset    = miner_reset_q;
   assign busy           = busy_q;
   assign exhausted      = exhausted_q;
   assign overflow       = overflow_q;
   assign miner_midstate = midstate_q;
   assign miner_data     = data_q;
   assign result_valid   = !fifo_empty;
   assign result_nonce   = fifo_head;

endmodule

// File: tb/tb_miner_work_ctrl.sv
// Directed scenarios plus a randomized run checked against a queue-based model of the controller.
module tb_miner_work_ctrl;

   localparam int RESET_CYCLES = 4;
   localparam int HOLDOFF      = 4;
   localparam int DONE         = 32;
   localparam int DEPTH        = 4;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_RUN  = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         work_valid;
   logic         work_ready;
   logic [255:0] work_midstate;
   logic [95:0]  work_data;
   logic [255:0] miner_midstate;
   logic [95:0]  miner_data;
   logic         miner_reset;
   logic [31:0]  miner_golden_nonce;
   logic         result_valid;
   logic         result_ready;
   logic [31:0]  result_nonce;
   logic         busy;
   logic         exhausted;
   logic         overflow;

   int checks = 0;
   int fails  = 0;

   int           mPhase;
   bit           mReady, mMreset, mBusy, mExh, mOvf, mHit;
   int           mLoadLeft;
   int           mRunCnt;
   logic [31:0]  mPrev;
   logic [31:0]  mQ[$];
   logic [255:0] mMid;
   logic [95:0]  mData;

   miner_work_ctrl #(
      .RESET_CYCLES(RESET_CYCLES),
      .HOLDOFF     (HOLDOFF),
      .DONE_CYCLES (33'(DONE)),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .work_valid        (work_valid),
      .work_ready        (work_ready),
      .work_midstate     (work_midstate),
      .work_data         (work_data),
      .miner_midstate    (miner_midstate),
      .miner_data        (miner_data),
      .miner_reset       (miner_reset),
      .miner_golden_nonce(miner_golden_nonce),
      .result_valid      (result_valid),
      .result_ready      (result_ready),
      .result_nonce      (result_nonce),
      .busy              (busy),
      .exhausted         (exhausted),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a phase plus countdown/run counters and a bounded queue of nonces.
   always @(posedge clk) begin
      if (!reset) begin
         mPhase = P_IDLE; mReady = 1'b0; mMreset = 1'b1; mBusy = 1'b0;
         mExh = 1'b0; mOvf = 1'b0; mQ.delete(); mMid = '0; mData = '0;
         mRunCnt = 0; mLoadLeft = 0; mPrev = '0;
      end else begin
         if (work_valid && mReady) begin
            mMid = work_midstate; mData = work_data; mQ.delete();
            mExh = 1'b0; mOvf = 1'b0; mPrev = '0; mRunCnt = 0;
            mLoadLeft = RESET_CYCLES; mPhase = P_LOAD;
         end else begin
            if (result_ready && mQ.size() > 0) void'(mQ.pop_front());
            if (mPhase == P_LOAD) begin
               mLoadLeft = mLoadLeft - 1;
               if (mLoadLeft == 0) mPhase = P_RUN;
            end else if (mPhase == P_RUN) begin
               mHit = (miner_golden_nonce != mPrev) && (miner_golden_nonce != 0) && (mRunCnt >= HOLDOFF);
               if (mHit) begin
                  if (mQ.size() < DEPTH) mQ.push_back(miner_golden_nonce);
                  else mOvf = 1'b1;
               end
               mPrev = miner_golden_nonce;
               mRunCnt = mRunCnt + 1;
               if (mRunCnt == DONE) begin
                  mExh = 1'b1;
                  mPhase = P_IDLE;
               end
            end
         end
         mReady  = (mPhase != P_LOAD);
         mMreset = (mPhase != P_RUN);
         mBusy   = (mPhase != P_IDLE);
      end
   end

   function automatic logic [37:0] modelFlags();
      logic [31:0] h;
      h = (mQ.size() != 0) ? mQ[0] : 32'h0;
      return {mReady, mMreset, mBusy, mExh, mOvf, (mQ.size() != 0), h};
   endfunction

   function automatic logic [37:0] dutFlags();
      return {work_ready, miner_reset, busy, exhausted, overflow, result_valid, result_nonce};
   endfunction

   function automatic logic [255:0] randMid();
      logic [255:0] m;
      for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
      return m;
   endfunction

   function automatic logic [95:0] randData();
      logic [95:0] d;
      for (int i = 0; i < 3; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Offers one work unit for a single cycle; returns at the negedge after the accept edge.
   task automatic applyWork(input logic [255:0] m, input logic [95:0] d);
      work_midstate = m;
      work_data = d;
      work_valid = 1'b1;
      miner_golden_nonce = '0;
      @(negedge clk);
      work_valid = 1'b0;
   endtask

   task automatic waitForRun(output bit ok);
      int n;
      n = 0;
      while (miner_reset === 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = (miner_reset === 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({work_ready, miner_reset, busy, exhausted, overflow, result_valid} !== 6'b010000) begin
         fails++;
         $display("[TB] FAIL reset_flags: got %b expected 010000", {work_ready, miner_reset, busy, exhausted, overflow, result_valid});
      end
      checks++;
      if (result_nonce !== 32'h0 || miner_data !== '0 || miner_midstate !== '0) begin
         fails++;
         $display("[TB] FAIL reset_regs: nonce %h data %h expected all zero", result_nonce, miner_data);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (work_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_release_ready: got %b expected 1", work_ready);
      end
   endtask

   task automatic test_load();
      logic [255:0] m;
      logic [95:0]  d;
      int n;
      m = randMid();
      d = randData();
      applyWork(m, d);
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL load_busy: got %b expected 1", busy);
      end
      checks++;
      if (miner_midstate !== m || miner_data !== d) begin
         fails++;
         $display("[TB] FAIL load_work: got %h/%h expected %h/%h", miner_midstate, miner_data, m, d);
      end
      n = 0;
      while (miner_reset === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != RESET_CYCLES) begin
         fails++;
         $display("[TB] FAIL load_reset_window: got %0d cycles expected %0d", n, RESET_CYCLES);
      end
   endtask

   // Entered at the first RUN cycle of the work loaded by test_load.
   task automatic test_holdoff();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 22; n++) begin
         if (n == 3) miner_golden_nonce = 32'h1234;
         if (n == 20) miner_golden_nonce = 32'h5678;
         @(negedge clk);
         if (result_valid === 1'b1 && result_nonce === 32'h1234) seen = 1'b1;
      end
      checks++;
      if (result_valid !== 1'b1 || result_nonce !== 32'h5678) begin
         fails++;
         $display("[TB] FAIL holdoff_push: got valid %b nonce %h expected 1 00005678", result_valid, result_nonce);
      end
      checks++;
      if (seen) begin
         fails++;
         $display("[TB] FAIL holdoff_masked: 00001234 reported, expected never");
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL holdoff_pop: got valid %b expected 0", result_valid);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] vals[5];
      logic [31:0] base;
      bit ok;
      applyWork(randMid(), randData());
      waitForRun(ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL overflow_run_timeout: miner_reset %b expected 0", miner_reset);
      end
      repeat (HOLDOFF) @(negedge clk);
      base = {8'($urandom_range(1, 255)), 24'($urandom)};
      for (int i = 0; i < 5; i++) begin
         vals[i] = base + 32'(i);
         miner_golden_nonce = vals[i];
         @(negedge clk);
      end
      checks++;
      if (overflow !== 1'b1 || result_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL overflow_flag: got ovf %b valid %b expected 1 1", overflow, result_valid);
      end
      result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (result_valid !== 1'b1 || result_nonce !== vals[i]) begin
            fails++;
            $display("[TB] FAIL overflow_pop%0d: got %b/%h expected 1/%h", i, result_valid, result_nonce, vals[i]);
         end
         @(negedge clk);
      end
      result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL overflow_drained: got valid %b expected 0", result_valid);
      end
   endtask

   task automatic test_exhaust();
      logic [31:0]  fv;
      logic [255:0] e;
      bit ok;
      int n;
      applyWork(randMid(), randData());
      waitForRun(ok);
      fv = $urandom | 32'h1;
      n = 0;
      while (miner_reset === 1'b0 && n < 100) begin
         if (n == DONE - 1) miner_golden_nonce = fv;
         n++;
         @(negedge clk);
      end
      checks++;
      if (!ok || n != DONE) begin
         fails++;
         $display("[TB] FAIL exhaust_run_len: got %0d run cycles expected %0d", n, DONE);
      end
      checks++;
      if (exhausted !== 1'b1 || busy !== 1'b0 || work_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL exhaust_flags: got exh %b busy %b ready %b expected 1 0 1", exhausted, busy, work_ready);
      end
      checks++;
      if (result_valid !== 1'b1 || result_nonce !== fv) begin
         fails++;
         $display("[TB] FAIL exhaust_final_push: got %b/%h expected 1/%h", result_valid, result_nonce, fv);
      end
      e = randMid();
      applyWork(e, randData());
      checks++;
      if (busy !== 1'b1 || exhausted !== 1'b0 || result_valid !== 1'b0 || miner_midstate !== e) begin
         fails++;
         $display("[TB] FAIL exhaust_reaccept: got busy %b exh %b valid %b expected 1 0 0", busy, exhausted, result_valid);
      end
   endtask

   // Entered during LOAD of the work accepted at the end of test_exhaust.
   task automatic test_preempt();
      logic [255:0] m;
      logic [95:0]  d;
      logic [31:0]  base;
      bit ok;
      waitForRun(ok);
      repeat (HOLDOFF) @(negedge clk);
      base = $urandom | 32'h100;
      for (int i = 0; i < 5; i++) begin
         miner_golden_nonce = base + 32'(i);
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!ok || overflow !== 1'b1 || result_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL preempt_setup: got ovf %b valid %b expected 1 1", overflow, result_valid);
      end
      m = randMid();
      d = randData();
      applyWork(m, d);
      checks++;
      if ({work_ready, miner_reset, busy, exhausted, overflow, result_valid} !== 6'b011000) begin
         fails++;
         $display("[TB] FAIL preempt_flags: got %b expected 011000", {work_ready, miner_reset, busy, exhausted, overflow, result_valid});
      end
      checks++;
      if (miner_midstate !== m || miner_data !== d) begin
         fails++;
         $display("[TB] FAIL preempt_work: got %h/%h expected %h/%h", miner_midstate, miner_data, m, d);
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] v1;
      bit ok;
      waitForRun(ok);
      repeat (HOLDOFF) @(negedge clk);
      v1 = $urandom | 32'h1;
      miner_golden_nonce = v1;
      @(negedge clk);
      miner_golden_nonce = v1 ^ 32'h8000_0000;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (!ok || result_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL midrun_setup: got valid %b expected 1", result_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({work_ready, miner_reset, busy, exhausted, overflow, result_valid} !== 6'b010000 ||
          result_nonce !== 32'h0 || miner_midstate !== '0 || miner_data !== '0) begin
         fails++;
         $display("[TB] FAIL midrun_reset: got flags %b nonce %h data %h expected 010000 0 0",
                  {work_ready, miner_reset, busy, exhausted, overflow, result_valid}, result_nonce, miner_data);
      end
      reset = 1'b1;
      miner_golden_nonce = '0;
      @(negedge clk);
      checks++;
      if (work_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL midrun_release: got ready %b expected 1", work_ready);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         checks++;
         if (dutFlags() !== modelFlags()) begin
            fails++;
            $display("[TB] FAIL random_flags cycle %0d: got %h expected %h", c, dutFlags(), modelFlags());
         end
         checks++;
         if ({miner_midstate, miner_data} !== {mMid, mData}) begin
            fails++;
            $display("[TB] FAIL random_work cycle %0d: got %h expected %h", c, miner_data, mData);
         end
         reset = ($urandom_range(0, 299) != 0);
         work_valid = ($urandom_range(0, 49) == 0);
         if (work_valid) begin
            work_midstate = randMid();
            work_data = randData();
         end
         result_ready = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 5))
               0: miner_golden_nonce = 32'h0;
               1: miner_golden_nonce = 32'h1;
               2: miner_golden_nonce = 32'h2;
               default: miner_golden_nonce = $urandom;
            endcase
         end
         @(negedge clk);
      end
      reset = 1'b1;
      work_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      work_valid = 1'b0;
      work_midstate = '0;
      work_data = '0;
      miner_golden_nonce = '0;
      result_ready = 1'b0;
      test_reset();
      test_load();
      test_holdoff();
      test_overflow();
      test_exhaust();
      test_preempt();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
